// File: rtl/uart_word_rx_pkg.sv
// Shared UART receive/transmit definitions: bit-FSM encoding,
// default bit timing and the sample width in bytes.
package uart_word_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CLEANUP
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEF = 625;
  localparam int BYTES_PER_SAMPLE = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Byte stream from the bit-level receiver to the sample assembler,
// plus the line-state hints the assembler timeout needs.
interface uart_word_rx_if;

  logic [7:0] rx_byte;
  logic       byte_val;
  logic       frame_err;
  logic       start_edge;
  logic       busy;

  modport master (
    output rx_byte,
    output byte_val,
    output frame_err,
    output start_edge,
    output busy
  );

  modport slave (
    input rx_byte,
    input byte_val,
    input frame_err,
    input start_edge,
    input busy
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer and bit FSM emitting one byte
// or one framing-error pulse in the stop-bit sample cycle.
module uart_rx_core
  import uart_word_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
  parameter int HALF_CLK_PERIOD = CLKS_PER_BIT / 2
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_uartrx,
  uart_word_rx_if.master rx
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CLK_PERIOD - 1);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  logic line;
  logic start_edge;
  logic stop_done;

  assign line       = sync_q[1];
  assign start_edge = (state_q == ST_IDLE) && prev_q && !line;
  assign stop_done  = (state_q == ST_STOP) && (cnt_q == BIT_END);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], i_uartrx};
    prev_d  = line;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = line ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLEANUP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx.rx_byte    = shift_q;
    rx.byte_val   = stop_done && line;
    rx.frame_err  = stop_done && !line;
    rx.start_edge = start_edge;
    rx.busy       = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/uart_word_rx.sv
// Assembles received UART bytes into 16-bit FIR samples, MSB byte
// first, discarding a half-built sample after an idle timeout.
module uart_word_rx
  import uart_word_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
  parameter int HALF_CLK_PERIOD = CLKS_PER_BIT / 2,
  parameter int TIMEOUT_BITS    = 20
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_uartrx,
  output logic [15:0] o_sample,
  output logic        o_sample_val,
  output logic        o_framing_err,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int TO_END = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = cnt_w(TO_END);
  localparam int IW     = cnt_w(BYTES_PER_SAMPLE);
  localparam int SW     = 8 * BYTES_PER_SAMPLE;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_END - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_SAMPLE - 1);

  uart_word_rx_if u_if ();

  uart_rx_core #(
    .CLKS_PER_BIT    (CLKS_PER_BIT),
    .HALF_CLK_PERIOD (HALF_CLK_PERIOD)
  ) u_core (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_uartrx (i_uartrx),
    .rx       (u_if.master)
  );

  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sample_q, sample_d;
  logic [TW-1:0] to_q, to_d;
  logic          val_q, val_d;
  logic          ferr_q, ferr_d;
  logic          tout_q, tout_d;

  logic          held;
  logic          idle_wait;
  logic          expire;
  logic [SW-1:0] acc_nxt;

  assign held      = (idx_q != '0);
  assign idle_wait = held && !u_if.busy && !u_if.start_edge;
  // A start edge in the expiry cycle keeps the held byte alive.
  assign expire    = idle_wait && (to_q == TO_LAST);
  assign acc_nxt   = {acc_q[SW-9:0], u_if.rx_byte};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      idx_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      to_q     <= '0;
      val_q    <= 1'b0;
      ferr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      to_q     <= to_d;
      val_q    <= val_d;
      ferr_q   <= ferr_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    to_d     = to_q;
    val_d    = 1'b0;
    ferr_d   = 1'b0;
    tout_d   = 1'b0;
    unique case (1'b1)
      u_if.byte_val: begin
        acc_d = acc_nxt;
        to_d  = '0;
        if (idx_q == IDX_LAST) begin
          sample_d = acc_nxt;
          val_d    = 1'b1;
          idx_d    = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      u_if.frame_err: begin
        idx_d  = '0;
        to_d   = '0;
        ferr_d = 1'b1;
      end
      expire: begin
        idx_d  = '0;
        to_d   = '0;
        tout_d = 1'b1;
      end
      default: begin
        if (idle_wait) to_d = to_q + TW'(1);
        else if (!held) to_d = '0;
      end
    endcase
  end

  assign o_sample      = sample_q;
  assign o_sample_val  = val_q;
  assign o_framing_err = ferr_q;
  assign o_timeout     = tout_q;
  assign o_busy        = u_if.busy;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 16 clocks per bit and a
// 4-bit-time sample timeout.
module tb_uart_word_rx;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_line = 1'b1;
  logic [15:0] o_sample;
  logic        o_sample_val;
  logic        o_framing_err;
  logic        o_timeout;
  logic        o_busy;

  uart_word_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_uartrx      (rx_line),
    .o_sample      (o_sample),
    .o_sample_val  (o_sample_val),
    .o_framing_err (o_framing_err),
    .o_timeout     (o_timeout),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int n_val = 0;
  int n_ferr = 0;
  int n_tout = 0;
  int n_ovl = 0;
  int val_cyc = 0;
  int tout_cyc = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (o_sample_val) begin
      n_val   <= n_val + 1;
      val_cyc <= cyc;
      got_q.push_back(o_sample);
    end
    if (o_framing_err) n_ferr <= n_ferr + 1;
    if (o_timeout) begin
      n_tout   <= n_tout + 1;
      tout_cyc <= cyc;
    end
    if (int'(o_sample_val) + int'(o_framing_err) + int'(o_timeout) > 1)
      n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           output int ts);
    ts = cyc;
    rx_line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      tick(CPB);
    end
    rx_line = stop;
    tick(CPB);
  endtask

  initial begin
    int t1;
    int t2;
    logic [15:0] s;
    logic [7:0] ef;

    rstn = 1'b0;
    rx_line = 1'b1;
    tick(5);
    chk("rst_sample", 32'(o_sample), 32'h0);
    chk("rst_val", 32'(o_sample_val), 32'h0);
    chk("rst_ferr", 32'(o_framing_err), 32'h0);
    chk("rst_tout", 32'(o_timeout), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    rstn = 1'b1;
    tick(5);

    send_byte(8'hA5, 1'b1, t1);
    send_byte(8'h3C, 1'b1, t2);
    tick(4);
    chk("a53c_count", 32'(n_val), 32'd1);
    chk("a53c_sample", 32'(o_sample), 32'hA53C);
    chk("a53c_latency", 32'(val_cyc), 32'(t2 + 155));

    t1 = cyc;
    rx_line = 1'b0;
    tick(3);
    rx_line = 1'b1;
    tick(2);
    chk("glitch_busy_hi", 32'(o_busy), 32'h1);
    tick(6);
    chk("glitch_busy_lo", 32'(o_busy), 32'h0);
    tick(20);
    chk("glitch_val", 32'(n_val), 32'd1);
    chk("glitch_ferr", 32'(n_ferr), 32'd0);
    chk("glitch_tout", 32'(n_tout), 32'd0);
    chk("glitch_hold", 32'(o_sample), 32'hA53C);

    send_byte(8'h12, 1'b0, t1);
    rx_line = 1'b1;
    tick(CPB);
    send_byte(8'h34, 1'b1, t1);
    send_byte(8'h56, 1'b1, t1);
    tick(4);
    chk("ferr_count", 32'(n_ferr), 32'd1);
    chk("ferr_val", 32'(n_val), 32'd2);
    chk("ferr_sample", 32'(o_sample), 32'h3456);

    send_byte(8'h77, 1'b1, t1);
    tick(70);
    chk("tout_count", 32'(n_tout), 32'd1);
    chk("tout_cycle", 32'(tout_cyc), 32'(t1 + 220));
    chk("tout_noval", 32'(n_val), 32'd2);
    send_byte(8'h01, 1'b1, t1);
    send_byte(8'h02, 1'b1, t1);
    tick(4);
    chk("post_tout_sample", 32'(o_sample), 32'h0102);
    chk("post_tout_val", 32'(n_val), 32'd3);

    send_byte(8'h77, 1'b1, t1);
    tick(57);
    send_byte(8'h88, 1'b1, t2);
    tick(80);
    chk("race_start_at", 32'(t2), 32'(t1 + 217));
    chk("race_tout", 32'(n_tout), 32'd1);
    chk("race_sample", 32'(o_sample), 32'h7788);
    chk("race_val", 32'(n_val), 32'd4);

    ef = 8'hEF;
    send_byte(8'hBE, 1'b1, t1);
    rx_line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_line = ef[i];
      tick(CPB);
    end
    chk("mid_busy", 32'(o_busy), 32'h1);
    rstn = 1'b0;
    tick(2);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_sample", 32'(o_sample), 32'h0);
    tick(2);
    rstn = 1'b1;
    rx_line = 1'b1;
    tick(100);
    chk("mid_rst_tout", 32'(n_tout), 32'd1);
    chk("mid_rst_val", 32'(n_val), 32'd4);
    send_byte(8'hCA, 1'b1, t1);
    send_byte(8'hFE, 1'b1, t1);
    tick(4);
    chk("cafe_sample", 32'(o_sample), 32'hCAFE);
    chk("cafe_val", 32'(n_val), 32'd5);

    got_q.delete();
    for (int k = 0; k < 100; k++) begin
      s = 16'($urandom_range(0, 65535));
      exp_q.push_back(s);
      send_byte(s[15:8], 1'b1, t1);
      send_byte(s[7:0], 1'b1, t1);
    end
    tick(4);
    chk("rand_count", 32'(got_q.size()), 32'd100);
    for (int k = 0; k < 100 && k < got_q.size(); k++)
      chk($sformatf("rand_%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    chk("rand_ferr", 32'(n_ferr), 32'd1);
    chk("rand_tout", 32'(n_tout), 32'd1);
    chk("pulse_overlap", 32'(n_ovl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
